// File: rtl/uart_rx.sv
// UART 8N1 receiver with a one-deep valid/ready holding register, framing-error and overrun pulses.
// Latency: stop bit sampled HALF+9*CLKS_PER_BIT cycles after start detect; byte/error visible one cycle later.
// Backpressure: rx_valid holds until rx_valid&rx_ready; a byte arriving while full is dropped with rx_overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = ($clog2(CLKS_PER_BIT) > 9) ? $clog2(CLKS_PER_BIT) : 9;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            good_q, good_d;      // good stop bit seen last cycle: deliver now
    logic            bad_q, bad_d;        // bad stop bit seen last cycle: flag error now
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            rx_sync;
    logic            tick;

    assign rx_sync = sync2_q;
    assign tick    = (cnt_q == '0);

    // Frame sequencing: start detect, mid-bit sampling of start/data/stop, break wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_sync) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                        cnt_d   = BIT_M1;
                    end else begin
                        state_d = S_IDLE;   // glitch shorter than half a bit
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_sync, shift_q[7:1]};
                    cnt_d   = BIT_M1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    // Back to IDLE at mid-stop so a following start bit is caught.
                    if (rx_sync) begin
                        good_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) yields a single error, not a stream of frames.
                if (rx_sync) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: load on good byte if empty or draining, else report overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ferr_d     = bad_q;
        ovr_d      = 1'b0;
        if (good_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset; synchroniser idles high.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= UART_RX;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_busy      = (state_q != S_IDLE);
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 434 clocks/bit: table of single frames plus
// hand-written glitch, back-to-back overrun/accept and mid-frame reset sequences.
module tb_uart_rx;

    localparam int CPB = 434;
    // Line driven low just after edge P0; E = P0+3; outputs visible after edge E+4124.
    localparam int LAT = 3 + 217 + 9 * CPB + 1;

    logic       clk;
    logic       reset;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int vld_rise_cnt = 0;
    int vld_rise_cyc = -1;
    int vld_fall_cnt = 0;
    int ferr_cnt     = 0;
    int ferr_cyc     = -1;
    int ovr_cnt      = 0;
    int ovr_cyc      = -1;
    logic prev_vld   = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled shortly after each edge (before the main thread's negedge).
    always @(posedge clk) begin
        #2;
        if (rx_valid && !prev_vld) begin
            vld_rise_cnt = vld_rise_cnt + 1;
            vld_rise_cyc = cyc;
        end
        if (!rx_valid && prev_vld) vld_fall_cnt = vld_fall_cnt + 1;
        if (rx_frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (rx_overrun) begin
            ovr_cnt = ovr_cnt + 1;
            ovr_cyc = cyc;
        end
        prev_vld = rx_valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 10-bit frame, CPB cycles per bit; call at a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RX = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic [7:0] exp_dat;
        int         exp_vld;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int p0, p0b, fb, ob, vb, vfb;

        vecs[0] = '{dat: 8'h55, stop: 1'b1, exp_dat: 8'h55, exp_vld: 1, exp_ferr: 0};
        vecs[1] = '{dat: 8'hA3, stop: 1'b0, exp_dat: 8'h55, exp_vld: 0, exp_ferr: 1};
        vecs[2] = '{dat: 8'h31, stop: 1'b1, exp_dat: 8'h31, exp_vld: 1, exp_ferr: 0};
        vecs[3] = '{dat: 8'h80, stop: 1'b1, exp_dat: 8'h80, exp_vld: 1, exp_ferr: 0};
        vecs[4] = '{dat: 8'h00, stop: 1'b1, exp_dat: 8'h00, exp_vld: 1, exp_ferr: 0};

        reset    = 1'b1;
        UART_RX  = 1'b1;
        rx_ready = 1'b0;
        wait_cyc(3);
        chk("reset_data",  rx_data,      0);
        chk("reset_valid", rx_valid,     0);
        chk("reset_busy",  rx_busy,      0);
        chk("reset_ferr",  rx_frame_err, 0);
        chk("reset_ovr",   rx_overrun,   0);
        reset = 1'b0;
        wait_cyc(10);

        // Table-driven single frames with rx_ready low during reception.
        for (int i = 0; i < 5; i++) begin
            fb = ferr_cnt; ob = ovr_cnt; vb = vld_rise_cnt;
            p0 = cyc;
            send_frame(vecs[i].dat, vecs[i].stop);
            if (!vecs[i].stop) begin
                wait_cyc(2000);
                chk("break_busy_held", rx_busy, 1);
                UART_RX = 1'b1;
                wait_cyc(4);
                chk("break_busy_release", rx_busy, 0);
            end
            chk($sformatf("v%0d_vld_rises", i), vld_rise_cnt - vb, vecs[i].exp_vld);
            if (vecs[i].exp_vld != 0)
                chk($sformatf("v%0d_vld_latency", i), vld_rise_cyc - p0, LAT);
            chk($sformatf("v%0d_data", i), rx_data, vecs[i].exp_dat);
            chk($sformatf("v%0d_valid", i), rx_valid, vecs[i].exp_vld);
            chk($sformatf("v%0d_ferr_cnt", i), ferr_cnt - fb, vecs[i].exp_ferr);
            if (vecs[i].exp_ferr != 0)
                chk($sformatf("v%0d_ferr_latency", i), ferr_cyc - p0, LAT);
            chk($sformatf("v%0d_ovr_cnt", i), ovr_cnt - ob, 0);
            if (vecs[i].exp_vld != 0) begin
                wait_cyc(20);
                chk($sformatf("v%0d_valid_hold", i), rx_valid, 1);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                chk($sformatf("v%0d_valid_drop", i), rx_valid, 0);
                chk($sformatf("v%0d_data_kept", i), rx_data, vecs[i].exp_dat);
            end
            wait_cyc(50);
        end

        // Glitch: 100 low cycles, START sample sees high and returns to IDLE.
        fb = ferr_cnt; ob = ovr_cnt; vb = vld_rise_cnt;
        p0 = cyc;
        UART_RX = 1'b0;
        wait_cyc(100);
        UART_RX = 1'b1;
        wait_cyc(3 + 217 - 1 - 100);
        chk("glitch_busy_before", rx_busy, 1);
        @(negedge clk);
        chk("glitch_busy_cyc", cyc - p0, 3 + 217);
        chk("glitch_busy_after", rx_busy, 0);
        wait_cyc(500);
        chk("glitch_no_vld",  vld_rise_cnt - vb, 0);
        chk("glitch_no_ferr", ferr_cnt - fb, 0);
        chk("glitch_no_ovr",  ovr_cnt - ob, 0);

        // Back-to-back 0x30, 0x31 with rx_ready low: second byte overruns.
        fb = ferr_cnt; ob = ovr_cnt; vb = vld_rise_cnt;
        p0 = cyc;
        send_frame(8'h30, 1'b1);
        p0b = cyc;
        send_frame(8'h31, 1'b1);
        wait_cyc(20);
        chk("b2b_vld_rises", vld_rise_cnt - vb, 1);
        chk("b2b_vld_latency", vld_rise_cyc - p0, LAT);
        chk("b2b_data_kept", rx_data, 8'h30);
        chk("b2b_valid", rx_valid, 1);
        chk("b2b_ovr_cnt", ovr_cnt - ob, 1);
        chk("b2b_ovr_latency", ovr_cyc - p0b, LAT);
        chk("b2b_no_ferr", ferr_cnt - fb, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("b2b_cleared", rx_valid, 0);
        wait_cyc(20);

        // Back-to-back again, accepting exactly in the second delivery cycle.
        fb = ferr_cnt; ob = ovr_cnt; vb = vld_rise_cnt; vfb = vld_fall_cnt;
        p0 = cyc;
        fork
            begin
                send_frame(8'h30, 1'b1);
                send_frame(8'h31, 1'b1);
            end
            begin
                wait_cyc(10 * CPB + LAT - 1);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        wait_cyc(20);
        chk("acc_data", rx_data, 8'h31);
        chk("acc_valid", rx_valid, 1);
        chk("acc_vld_rises", vld_rise_cnt - vb, 1);
        chk("acc_vld_falls", vld_fall_cnt - vfb, 0);
        chk("acc_no_ovr", ovr_cnt - ob, 0);
        chk("acc_no_ferr", ferr_cnt - fb, 0);

        // Reset pulse during data bit 4 of 0xFF, with a full holding register.
        fb = ferr_cnt; vb = vld_rise_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_cyc(5 * CPB + 200);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_data",  rx_data,      0);
                chk("rst_valid", rx_valid,     0);
                chk("rst_busy",  rx_busy,      0);
                chk("rst_ferr",  rx_frame_err, 0);
                chk("rst_ovr",   rx_overrun,   0);
            end
        join
        wait_cyc(500);
        chk("rst_no_vld", vld_rise_cnt - vb, 0);
        chk("rst_ferr_max1", ((ferr_cnt - fb) <= 1) ? 1 : 0, 1);
        vb = vld_rise_cnt;
        p0 = cyc;
        send_frame(8'h7E, 1'b1);
        wait_cyc(10);
        chk("post_rst_vld_rises", vld_rise_cnt - vb, 1);
        chk("post_rst_latency", vld_rise_cyc - p0, LAT);
        chk("post_rst_data", rx_data, 8'h7E);
        chk("post_rst_valid", rx_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the DE0 Nano design. It deserialises 8N1 frames arriving on `UART_RX` at a fixed baud rate derived from `CLOCK_50`. It presents each received byte to downstream logic through a one-deep holding register with a valid/ready handshake, and reports framing errors and overruns. It is the receive-side counterpart of the board's UART transmitter and shares its line format: idle high, start bit 0, 8 data bits LSB first, stop bit 1.

## Interface
- `CLKS_PER_BIT`, 434 — `CLOCK_50` cycles per bit (50 MHz / 115200, rounded); legal range ≥ 4
- `CLOCK_50`  in  1  system clock, the only clock
- `reset`  in  1  synchronous, active-high reset, sampled on `CLOCK_50` rising edge
- `UART_RX`  in  1  asynchronous serial input from the UART board
- `rx_data`  out  8  received byte; valid while `rx_valid`=1
- `rx_valid`  out  1  holding register full; stays high until accepted
- `rx_ready`  in  1  consumer accepts the byte in any cycle where `rx_valid`&`rx_ready`
- `rx_busy`  out  1  high whenever the state is not IDLE
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled as 0
- `rx_overrun`  out  1  one-cycle pulse: a good byte completed while the holding register was full and not being accepted

## Operation
- Input synchroniser: `UART_RX` passes through two flops to give `rx_sync`, with 2-cycle latency. Only `rx_sync` is used internally. Both flops reset to 1.
- Bit counter: a ≥9-bit cycle counter and a 3-bit data-bit index. `HALF` = `CLKS_PER_BIT`/2, integer floor.
- IDLE: if `rx_sync`=0, load the counter for `HALF` cycles and go to START. Call this cycle E.
- START: at E+`HALF`, sample `rx_sync`.
  - If 0, go to DATA with index 0.
  - If 1, it was a glitch: return to IDLE with no outputs.
- DATA: sample every `CLKS_PER_BIT` cycles. Bit k is sampled at E+`HALF`+(k+1)·`CLKS_PER_BIT` and shifted in LSB first. After k=7, go to STOP.
- STOP: sample at E+`HALF`+9·`CLKS_PER_BIT`.
  - If 1, the byte is good. Deliver it as below, then go to IDLE.
  - If 0, pulse `rx_frame_err` next cycle, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: remain here until `rx_sync`=1, then go to IDLE. A break condition therefore yields one error, not repeated frames.
- Delivery, evaluated in the cycle after the stop sample:
  - Holding register empty, or being accepted that same cycle: load `rx_data` and set `rx_valid`=1.
  - Holding register full and not accepted: drop the new byte, pulse `rx_overrun`, and leave `rx_data`/`rx_valid` unchanged.
- Handshake: `rx_valid`&`rx_ready` with no simultaneous load clears `rx_valid` on the next edge. `rx_ready` has no effect while `rx_valid`=0.
- `rx_data` changes only on a load.

## Timing
- Reset values:
  - state IDLE
  - `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `rx_frame_err`=0, `rx_overrun`=0
  - synchroniser flops = 1, counters = 0
- Reset asserted mid-frame: on the next edge, abandon the frame, go to IDLE and clear `rx_valid`. No error pulse is generated.
- `rx_busy` rises the cycle after E. It falls the cycle after the final STOP or WAIT_HIGH exit.
- Latency with the default parameter:
  - stop sample at E+4123
  - `rx_valid` (or `rx_frame_err`/`rx_overrun`) high from E+4124
  - E lags the `UART_RX` falling edge by 2–3 cycles
- Back-to-back frames: a start bit beginning immediately after the stop-bit sample is detected. IDLE is re-entered before the stop bit ends, giving ~`HALF` cycles of slack.
- Baud tolerance: sampling at mid-bit tolerates ±4% cumulative error over 10 bits.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Send 0x55 at exactly 434 cycles/bit with `rx_ready`=0 → `rx_data`=0x55 and `rx_valid`=1 at E+4124. `rx_valid` holds until `rx_ready` is pulsed, then drops on the next edge. No error pulses.
- Drive `UART_RX` low for 100 cycles, then high → no `rx_valid`, `rx_frame_err` or `rx_overrun`. `rx_busy` returns to 0 after E+217.
- Send 0xA3 with the stop bit driven 0, then hold the line low 2000 more cycles → a single `rx_frame_err` pulse at E+4124 and no `rx_valid`. `rx_busy` stays high until the line returns high. A following good 0x31 is then received correctly.
- Send 0x30 then 0x31 back-to-back with `rx_ready`=0 → `rx_data`=0x30 is retained. One `rx_overrun` pulse occurs at the second frame's delivery cycle.
- Repeat with `rx_ready` asserted exactly in the second delivery cycle → `rx_data`=0x31, `rx_valid` stays 1, no `rx_overrun`.
- Assert `reset` for 1 cycle during data bit 4 of 0xFF → all outputs at reset values the next cycle. The remaining bits produce no `rx_valid`, and at most one `rx_frame_err` (from the trailing bits treated as start and stop). A subsequent 0x7E, sent after the line is idle, is received correctly.
